// File: rtl/branch_dir_predictor.sv
// Gshare branch direction predictor.
// Fetch gets a combinational taken/not-taken prediction and the table index it used.
// EX returns that index with the resolved outcome to train a table of 2-bit
// saturating counters and a non-speculative global history register.
// Update and mispredict counters are kept for performance debug.
module branch_dir_predictor #(
  parameter int IDX_W  = 4,  // table holds 2**IDX_W counters
  parameter int HIST_W = 4,  // legal range 1..IDX_W
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       cpc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  output logic [HIST_W-1:0] ghr,
  output logic [STAT_W-1:0] n_updates,
  output logic [STAT_W-1:0] n_mispredicts
);

  localparam int unsigned N_ENTRIES = 1 << IDX_W;

  logic [1:0]        ctr_q [N_ENTRIES];
  logic [HIST_W-1:0] ghr_q;
  logic [STAT_W-1:0] n_upd_q;
  logic [STAT_W-1:0] n_mis_q;
  logic [1:0]        ctr_cur;
  logic [1:0]        ctr_next;

  // Only the word-index bits of the PC select a table entry.
  logic unused_cpc_bits;
  assign unused_cpc_bits = ^{cpc[31:IDX_W+2], cpc[1:0]};

  // Lookup: hash PC word index with zero-extended history, read the counter MSB.
  // The lookup sees the registered table and history, so a same-cycle update
  // becomes visible one cycle later.
  assign pred_idx   = cpc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign pred_taken = ctr_q[pred_idx][1];

  // Next value of the counter being trained: step toward the outcome, clamp at the ends.
  always_comb begin
    // NOTE: ctr_next gets a default before any branch so no path leaves it
    // unassigned; a missing default in always_comb would infer a latch.
    ctr_next = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  assign ctr_cur = ctr_q[upd_idx];

  // Counter table: reset to weakly not-taken, train the returned index on resolution.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      // NOTE: the table is reset entry by entry because lookups must never
      // return X after reset; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < int'(N_ENTRIES); i++) ctr_q[i] <= 2'b01;
    end else if (upd_en) begin
      // NOTE: sequential state uses non-blocking assignments so every reader
      // in this clock edge sees the pre-update value.
      ctr_q[upd_idx] <= ctr_next;
    end
  end

  // Global history: shift in the resolved direction, oldest bit falls off the top.
  // The truncating cast handles HIST_W == 1 without a special case.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ghr_q <= '0;
    end else if (upd_en) begin
      ghr_q <= HIST_W'({ghr_q, upd_taken});
    end
  end

  // Statistics: saturating counts of resolutions and of mispredicted resolutions.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      n_upd_q <= '0;
      n_mis_q <= '0;
    end else if (upd_en) begin
      if (n_upd_q != '1) n_upd_q <= n_upd_q + 1'b1;
      if (upd_mispredict && (n_mis_q != '1)) n_mis_q <= n_mis_q + 1'b1;
    end
  end

  assign ghr           = ghr_q;
  assign n_updates     = n_upd_q;
  assign n_mispredicts = n_mis_q;

endmodule
